// File: rtl/rob_commit_monitor_pkg.sv
// Shared encodings for the ROB commit monitor: error codes and FSM states.
package rob_commit_monitor_pkg;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ORDER     = 3'd1;
  localparam logic [2:0] ERR_NOT_READY = 3'd2;
  localparam logic [2:0] ERR_MISMATCH  = 3'd3;
  localparam logic [2:0] ERR_DUP_CDB   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

endpackage

// File: rtl/rob_result_table.sv
// Per-ROB-tag store of CDB results: a valid bit plus the broadcast value.
// The write port also reports whether the addressed entry was already valid,
// so the caller can detect a second broadcast on a live tag.
module rob_result_table #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_hit,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_en,
  input  logic [TAG_W-1:0]  clr_tag
);

  localparam int DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // Valid bits: a write sets, a clear resets; clear wins on a same-tag collision
  // so a broadcast bypassed straight into a retiring commit leaves the entry empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_tag]  <= 1'b1;
      if (clr_en) valid_q[clr_tag] <= 1'b0;
    end
  end

  // Result data is only ever consumed behind its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_tag] <= wr_data;
  end

  assign wr_hit   = valid_q[wr_tag];
  assign rd_valid = valid_q[rd_tag];
  assign rd_data  = data_q[rd_tag];

endmodule

// File: rtl/rob_commit_monitor.sv
// Retire-side checker for the Tomasulo core. Records CDB broadcasts per ROB
// tag, checks each commit for in-order tag, result presence and value match,
// keeps an architectural shadow register file and ends the run with done or
// fail (first error wins and is latched with its code and tag).
//
// Handshake: cdb_valid and commit_valid are single-cycle strobes sampled on
// the rising clock edge; there is no back-pressure, every strobe presented
// while the FSM is in RUN is consumed in that cycle.
module rob_commit_monitor
  import rob_commit_monitor_pkg::*;
#(
  parameter int TAG_W       = 3,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 8,
  parameter int EXP_COMMITS = 8,
  parameter int MAX_CYCLES  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_result,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [DATA_W-1:0] commit_value,
  input  logic [REG_W-1:0]  arch_rd_addr,
  output logic [DATA_W-1:0] arch_rd_data,
  output logic [CNT_W-1:0]  commit_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic              fail,
  output logic [2:0]        err_code,
  output logic [TAG_W-1:0]  err_tag
);

  localparam int REG_N = 1 << REG_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXP_COMMITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);

  mon_state_e        state_q, state_d;
  logic [TAG_W-1:0]  head_q;
  logic [CNT_W-1:0]  commit_count_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [2:0]        err_code_q;
  logic [TAG_W-1:0]  err_tag_q;
  logic [DATA_W-1:0] shadow_q [REG_N];

  logic              tbl_wr_hit;
  logic              tbl_rd_valid;
  logic [DATA_W-1:0] tbl_rd_data;

  logic              in_run;
  logic              bypass;
  logic              entry_valid;
  logic [DATA_W-1:0] entry_data;
  logic              order_err;
  logic              not_ready_err;
  logic              mismatch_err;
  logic              dup_err;
  logic              timeout_err;
  logic              err_any;
  logic              accept;
  logic              upd;
  logic [2:0]        err_code_d;
  logic [TAG_W-1:0]  err_tag_d;

  rob_result_table #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (upd && cdb_valid),
    .wr_tag   (cdb_tag),
    .wr_data  (cdb_result),
    .wr_hit   (tbl_wr_hit),
    .rd_tag   (commit_tag),
    .rd_valid (tbl_rd_valid),
    .rd_data  (tbl_rd_data),
    .clr_en   (upd && accept),
    .clr_tag  (commit_tag)
  );

  // Commit checks in priority order; a same-tag broadcast bypasses the table.
  always_comb begin
    in_run        = (state_q == ST_RUN);
    bypass        = cdb_valid && commit_valid && (cdb_tag == commit_tag);
    entry_valid   = bypass ? 1'b1 : tbl_rd_valid;
    entry_data    = bypass ? cdb_result : tbl_rd_data;
    order_err     = commit_valid && (commit_tag != head_q);
    not_ready_err = commit_valid && !order_err && !entry_valid;
    mismatch_err  = commit_valid && !order_err && entry_valid && (commit_value != entry_data);
    accept        = commit_valid && !order_err && entry_valid && !mismatch_err;
    dup_err       = cdb_valid && tbl_wr_hit;
    timeout_err   = (cycle_count_q >= MAX_CNT);
    err_any       = in_run && (order_err || not_ready_err || mismatch_err || dup_err || timeout_err);
    upd           = in_run && !err_any;

    err_code_d = ERR_NONE;
    err_tag_d  = '0;
    if (order_err) begin
      err_code_d = ERR_ORDER;
      err_tag_d  = commit_tag;
    end else if (not_ready_err) begin
      err_code_d = ERR_NOT_READY;
      err_tag_d  = commit_tag;
    end else if (mismatch_err) begin
      err_code_d = ERR_MISMATCH;
      err_tag_d  = commit_tag;
    end else if (dup_err) begin
      err_code_d = ERR_DUP_CDB;
      err_tag_d  = cdb_tag;
    end else if (timeout_err) begin
      err_code_d = ERR_TIMEOUT;
      err_tag_d  = '0;
    end
  end

  // Next state: any error in RUN beats a completing commit in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (err_any) state_d = ST_FAIL;
        else if (accept && (commit_count_q == LAST_CNT)) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // State register; DONE and FAIL hold until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Head pointer and counters advance only on clean RUN cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q         <= '0;
      commit_count_q <= '0;
      cycle_count_q  <= '0;
    end else if (upd) begin
      if (accept) begin
        head_q         <= head_q + 1'b1;
        commit_count_q <= commit_count_q + 1'b1;
      end
      if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + 1'b1;
    end
  end

  // First error is latched with its code and tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_code_q <= ERR_NONE;
      err_tag_q  <= '0;
    end else if (err_any) begin
      err_code_q <= err_code_d;
      err_tag_q  <= err_tag_d;
    end
  end

  // Architectural shadow registers; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) shadow_q[i] <= '0;
    end else if (upd && accept && (commit_rd != '0)) begin
      shadow_q[commit_rd] <= commit_value;
    end
  end

  assign arch_rd_data = (arch_rd_addr == '0) ? '0 : shadow_q[arch_rd_addr];
  assign commit_count = commit_count_q;
  assign cycle_count  = cycle_count_q;
  assign done         = (state_q == ST_DONE);
  assign fail         = (state_q == ST_FAIL);
  assign err_code     = err_code_q;
  assign err_tag      = err_tag_q;

endmodule

// File: tb/tb_rob_commit_monitor.sv
// Directed bench for rob_commit_monitor: a default instance (8 commits to done)
// and a second instance with EXP_COMMITS=10 share all inputs.
module tb_rob_commit_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_result = '0;
  logic        commit_valid = 1'b0;
  logic [2:0]  commit_tag = '0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_value = '0;
  logic [4:0]  arch_rd_addr = '0;

  logic [31:0] arch_rd_data, w_arch_rd_data;
  logic [7:0]  commit_count, w_commit_count;
  logic [7:0]  cycle_count, w_cycle_count;
  logic        done, w_done, fail, w_fail;
  logic [2:0]  err_code, w_err_code;
  logic [2:0]  err_tag, w_err_tag;

  rob_commit_monitor dut (
    .clk(clk), .reset(reset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .arch_rd_addr(arch_rd_addr), .arch_rd_data(arch_rd_data),
    .commit_count(commit_count), .cycle_count(cycle_count), .done(done), .fail(fail),
    .err_code(err_code), .err_tag(err_tag)
  );

  rob_commit_monitor #(.EXP_COMMITS(10)) dut_wrap (
    .clk(clk), .reset(reset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .arch_rd_addr(arch_rd_addr), .arch_rd_data(w_arch_rd_data),
    .commit_count(w_commit_count), .cycle_count(w_cycle_count), .done(w_done), .fail(w_fail),
    .err_code(w_err_code), .err_tag(w_err_tag)
  );

  // ---------------- scoreboard ----------------
  localparam logic [1:0] K_COMMIT = 2'd0;
  localparam logic [1:0] K_DONE   = 2'd1;
  localparam logic [1:0] K_FAIL   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] cnt;
    logic [2:0] code;
    logic [2:0] tag;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] cnt,
                         input logic [2:0] code, input logic [2:0] tag);
    ev_t e;
    e.kind = kind; e.cnt = cnt; e.code = code; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [1:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", {62'd0, kind}, 64'h3);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == K_COMMIT) chk("event_commit_count", commit_count, e.cnt);
      if (e.kind == K_FAIL) begin
        chk("event_err_code", err_code, e.code);
        chk("event_err_tag", err_tag, e.tag);
      end
    end
  endtask

  // Monitor: reacts to the DUT's own output events, away from the active edge.
  logic [7:0] last_cc = '0;
  logic       last_done = 1'b0;
  logic       last_fail = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      last_cc = '0; last_done = 1'b0; last_fail = 1'b0;
    end else begin
      if (commit_count != last_cc) check_ev(K_COMMIT);
      if (done && !last_done)      check_ev(K_DONE);
      if (fail && !last_fail)      check_ev(K_FAIL);
      last_cc = commit_count; last_done = done; last_fail = fail;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    commit_valid = 1'b0; commit_tag = '0; commit_rd = '0; commit_value = '0;
  endtask

  task automatic set_inputs(input logic cv, input logic [2:0] ct, input logic [31:0] cr,
                            input logic mv, input logic [2:0] mt, input logic [4:0] rd,
                            input logic [31:0] mval);
    cdb_valid = cv; cdb_tag = ct; cdb_result = cr;
    commit_valid = mv; commit_tag = mt; commit_rd = rd; commit_value = mval;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic drive(input logic cv, input logic [2:0] ct, input logic [31:0] cr,
                       input logic mv, input logic [2:0] mt, input logic [4:0] rd,
                       input logic [31:0] mval);
    set_inputs(cv, ct, cr, mv, mt, rd, mval);
    step();
  endtask

  task automatic check_zero_outputs(input string tag_s);
    chk({tag_s, "_commit_count"}, commit_count, 0);
    chk({tag_s, "_cycle_count"}, cycle_count, 0);
    chk({tag_s, "_done"}, done, 0);
    chk({tag_s, "_fail"}, fail, 0);
    chk({tag_s, "_err_code"}, err_code, 0);
    chk({tag_s, "_err_tag"}, err_tag, 0);
    chk({tag_s, "_w_fail"}, w_fail, 0);
    chk({tag_s, "_w_commit_count"}, w_commit_count, 0);
  endtask

  // Holds reset low 3 cycles, checks, releases right after a rising edge.
  task automatic apply_reset(input bit full);
    reset = 1'b0;
    idle_inputs();
    arch_rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("rst");
    if (full) begin
      for (int i = 0; i < 32; i++) begin
        arch_rd_addr = 5'(i);
        #1;
        chk("rst_arch_rd_data", arch_rd_data, 0);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic read_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    arch_rd_addr = a;
    #1;
    chk(name, arch_rd_data, exp);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset
    apply_reset(1'b1);

    // Clean run with wrap: tags 0..7,0,1; main instance is done after 8
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(i % 8), 32'h100 + 32'(i), 1'b0, '0, '0, '0);
      if (i < 8) push_ev(K_COMMIT, 8'(i + 1), 3'd0, 3'd0);
      if (i == 7) push_ev(K_DONE, 8'd8, 3'd0, 3'd0);
      drive(1'b0, '0, '0, 1'b1, 3'(i % 8), 5'(i + 1), 32'h100 + 32'(i));
    end
    drain("clean_drain");
    chk("clean_done", done, 1);
    chk("clean_fail", fail, 0);
    chk("clean_commit_count", commit_count, 8);
    chk("clean_cycle_count", cycle_count, 16);
    chk("clean_err_code", err_code, 0);
    read_reg("clean_reg5", 5'd5, 32'h104);
    read_reg("clean_reg9_after_done", 5'd9, 32'h0);
    chk("wrap_reg9", w_arch_rd_data, 32'h108);
    read_reg("clean_reg0", 5'd0, 32'h0);
    arch_rd_addr = 5'd10;
    #1;
    chk("wrap_reg10", w_arch_rd_data, 32'h109);
    chk("wrap_done", w_done, 1);
    chk("wrap_fail", w_fail, 0);
    chk("wrap_commit_count", w_commit_count, 10);
    chk("wrap_cycle_count", w_cycle_count, 20);

    // Same-cycle bypass accepted; old value visible before the write edge
    apply_reset(1'b0);
    arch_rd_addr = 5'd3;
    push_ev(K_COMMIT, 8'd1, 3'd0, 3'd0);
    set_inputs(1'b1, 3'd0, 32'hAB, 1'b1, 3'd0, 5'd3, 32'hAB);
    @(negedge clk);
    chk("bypass_old_read", arch_rd_data, 32'h0);
    step();
    // Different tags in the same cycle are independent
    drive(1'b1, 3'd1, 32'h22, 1'b0, '0, '0, '0);
    push_ev(K_COMMIT, 8'd2, 3'd0, 3'd0);
    drive(1'b1, 3'd2, 32'h33, 1'b1, 3'd1, 5'd4, 32'h22);
    push_ev(K_COMMIT, 8'd3, 3'd0, 3'd0);
    drive(1'b0, '0, '0, 1'b1, 3'd2, 5'd5, 32'h33);
    drain("bypass_drain");
    read_reg("bypass_reg3", 5'd3, 32'hAB);
    read_reg("bypass_reg4", 5'd4, 32'h22);
    read_reg("bypass_reg5", 5'd5, 32'h33);
    chk("bypass_commit_count", commit_count, 3);
    chk("bypass_fail", fail, 0);

    // Bypass with wrong value -> mismatch
    apply_reset(1'b0);
    push_ev(K_FAIL, 8'd0, 3'd3, 3'd0);
    drive(1'b1, 3'd0, 32'hAB, 1'b1, 3'd0, 5'd3, 32'hAC);
    drain("mismatch_drain");
    chk("mismatch_err_code", err_code, 3);
    chk("mismatch_commit_count", commit_count, 0);
    read_reg("mismatch_reg3", 5'd3, 32'h0);

    // Out-of-order commit
    apply_reset(1'b0);
    push_ev(K_FAIL, 8'd0, 3'd1, 3'd2);
    drive(1'b1, 3'd2, 32'h5, 1'b1, 3'd2, 5'd1, 32'h5);
    drain("order_drain");
    chk("order_err_tag", err_tag, 2);

    // Commit with no broadcast
    apply_reset(1'b0);
    push_ev(K_FAIL, 8'd0, 3'd2, 3'd0);
    drive(1'b0, '0, '0, 1'b1, 3'd0, 5'd1, 32'h7);
    drain("not_ready_drain");
    chk("not_ready_err_code", err_code, 2);

    // Duplicate broadcast, then everything stays frozen
    apply_reset(1'b0);
    drive(1'b1, 3'd4, 32'h1, 1'b0, '0, '0, '0);
    push_ev(K_FAIL, 8'd0, 3'd4, 3'd4);
    drive(1'b1, 3'd4, 32'h2, 1'b0, '0, '0, '0);
    drive(1'b1, 3'd0, 32'h9, 1'b1, 3'd0, 5'd1, 32'h9);
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    drain("dup_drain");
    chk("dup_frozen_commit_count", commit_count, 0);
    chk("dup_frozen_err_code", err_code, 4);
    chk("dup_frozen_err_tag", err_tag, 4);
    chk("dup_fail", fail, 1);
    read_reg("dup_frozen_reg1", 5'd1, 32'h0);

    // Timeout after 30 idle cycles
    apply_reset(1'b0);
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("timeout_early_fail", fail, 0);
    chk("timeout_cycle_count_28", cycle_count, 28);
    push_ev(K_FAIL, 8'd0, 3'd5, 3'd0);
    for (int i = 0; i < 10 && !fail; i++) @(negedge clk);
    chk("timeout_fail", fail, 1);
    drain("timeout_drain");

    // Asynchronous reset mid-run clears immediately
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check_zero_outputs("async_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
